// File: rtl/pipelined_control.sv
// pipelined_control: ID-stage control decode, load-use hazard detection and
// the ID/EX control register of a pipelined MIPS core.
// Optional feature macro: MULT_SEQ_EN enables a multi-cycle mul sequencer
// (IDLE/MUL_BUSY FSM) that holds ID/EX for MUL_LATENCY cycles.
module pipelined_control #(
  parameter int REG_ADDR_W  = 5,
  parameter int ALUOP_W     = 4,
  parameter int MUL_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  input  logic [5:0]            OpCode,
  input  logic [5:0]            Funct,
  input  logic [REG_ADDR_W-1:0] Rs,
  input  logic [REG_ADDR_W-1:0] Rt,
  input  logic [REG_ADDR_W-1:0] Rd,
  input  logic                  flush,
  output logic                  stall_if,
  output logic                  mul_busy,
  output logic                  ex_valid,
  output logic [1:0]            ex_PCSrc,
  output logic [2:0]            ex_Branch,
  output logic                  ex_RegWrite,
  output logic [1:0]            ex_RegDst,
  output logic                  ex_MemRead,
  output logic                  ex_MemWrite,
  output logic [1:0]            ex_MemtoReg,
  output logic                  ex_ALUSrc1,
  output logic                  ex_ALUSrc2,
  output logic                  ex_ExtOp,
  output logic                  ex_LuOp,
  output logic [ALUOP_W-1:0]    ex_ALUOp,
  output logic [REG_ADDR_W-1:0] ex_WriteReg
);

  if (MUL_LATENCY < 1) begin : g_lat_chk
    $error("MUL_LATENCY must be at least 1");
  end

  typedef struct packed {
    logic [1:0]            pc_src;
    logic [2:0]            branch;
    logic                  reg_write;
    logic [1:0]            reg_dst;
    logic                  mem_read;
    logic                  mem_write;
    logic [1:0]            mem_to_reg;
    logic                  alu_src1;
    logic                  alu_src2;
    logic                  ext_op;
    logic                  lu_op;
    logic [ALUOP_W-1:0]    alu_op;
    logic [REG_ADDR_W-1:0] write_reg;
  } ctrl_t;

  ctrl_t dec;
  ctrl_t ctrl_d, ctrl_q;
  logic  valid_d, valid_q;
  logic  is_r, is_jr, is_jalr, is_jal, is_mul, reads_rt;
  logic  hazard, mul_busy_w, kill_w;

  assign is_r     = (OpCode == 6'h00);
  assign is_jr    = is_r && (Funct == 6'h08);
  assign is_jalr  = is_r && (Funct == 6'h09);
  assign is_jal   = (OpCode == 6'h03);
  assign is_mul   = (OpCode == 6'h1c) && (Funct == 6'h02);
  assign reads_rt = is_r || (OpCode inside {6'h04, 6'h05, 6'h2b});

  // Decode OpCode/Funct of the IF/ID instruction into the control bundle
  always_comb begin
    dec = '0;
    if (OpCode inside {6'h02, 6'h03})  dec.pc_src = 2'b01;
    else if (is_jr || is_jalr)         dec.pc_src = 2'b10;
    case (OpCode)
      6'h04:   dec.branch = 3'd1;
      6'h05:   dec.branch = 3'd2;
      6'h06:   dec.branch = 3'd3;
      6'h07:   dec.branch = 3'd4;
      6'h01:   dec.branch = 3'd5;
      default: dec.branch = 3'd0;
    endcase
    dec.reg_write = !((OpCode inside {6'h2b, 6'h01, 6'h04, 6'h05, 6'h06, 6'h07, 6'h02})
                      || is_jr);
    if (is_jal || is_jalr)
      dec.reg_dst = 2'b10;
    else if (OpCode inside {6'h23, 6'h0f, 6'h08, 6'h09, 6'h0c, 6'h0a, 6'h0b})
      dec.reg_dst = 2'b00;
    else
      dec.reg_dst = 2'b01;
    dec.mem_read  = (OpCode == 6'h23);
    dec.mem_write = (OpCode == 6'h2b);
    if (OpCode == 6'h23)           dec.mem_to_reg = 2'b01;
    else if (is_jal || is_jalr)    dec.mem_to_reg = 2'b10;
    dec.alu_src2 = OpCode inside {6'h23, 6'h2b, 6'h0f, 6'h08, 6'h09, 6'h0c, 6'h0a, 6'h0b};
    dec.alu_src1 = is_r && (Funct inside {6'h00, 6'h02, 6'h03});
    dec.ext_op   = (OpCode != 6'h0c);
    dec.lu_op    = (OpCode == 6'h0f);
    if (is_r)                                                  dec.alu_op[2:0] = 3'b010;
    else if (OpCode inside {6'h04, 6'h05})                     dec.alu_op[2:0] = 3'b001;
    else if (OpCode == 6'h0c)                                  dec.alu_op[2:0] = 3'b100;
    else if (OpCode inside {6'h0a, 6'h0b, 6'h06, 6'h07, 6'h01}) dec.alu_op[2:0] = 3'b101;
    else if (is_mul)                                           dec.alu_op[2:0] = 3'b110;
    dec.alu_op[ALUOP_W-1] = OpCode[0];
    case (dec.reg_dst)
      2'b10:   dec.write_reg = REG_ADDR_W'(31);
      2'b00:   dec.write_reg = Rt;
      default: dec.write_reg = Rd;
    endcase
  end

  assign hazard = valid_q && ctrl_q.mem_read && (ctrl_q.write_reg != '0) && instr_valid &&
                  ((ctrl_q.write_reg == Rs) || ((ctrl_q.write_reg == Rt) && reads_rt));

  // A flushed or pending-kill instruction is discarded, so it must not freeze fetch
  assign stall_if = (hazard && !flush && !kill_w) || mul_busy_w;
  assign mul_busy = mul_busy_w;

`ifdef MULT_SEQ_EN
  localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             kill_d, kill_q;
  logic             issue_mul;

  assign issue_mul  = (state_q == IDLE) && !flush && !kill_q && !hazard && instr_valid && is_mul;
  assign mul_busy_w = (state_q == MUL_BUSY);
  assign kill_w     = kill_q;

  // Mul sequencer next state: count down the remaining busy cycles, remember flushes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kill_d  = kill_q;
    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (issue_mul) begin
          cnt_d = CNT_W'(MUL_LATENCY - 1);
          if (MUL_LATENCY > 1) state_d = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (flush) kill_d = 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Mul sequencer state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kill_q  <= kill_d;
    end
  end
`else
  assign mul_busy_w = 1'b0;
  assign kill_w     = 1'b0;
`endif

  // ID/EX next value: hold for mul, bubble on kill/hazard/empty slot, else load
  always_comb begin
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    if (mul_busy_w) begin
      ctrl_d  = ctrl_q;
      valid_d = valid_q;
    end else if (flush || kill_w || hazard || !instr_valid) begin
      ctrl_d  = '0;
      valid_d = 1'b0;
    end else begin
      ctrl_d  = dec;
      valid_d = 1'b1;
    end
  end

  // ID/EX control register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_PCSrc    = ctrl_q.pc_src;
  assign ex_Branch   = ctrl_q.branch;
  assign ex_RegWrite = ctrl_q.reg_write;
  assign ex_RegDst   = ctrl_q.reg_dst;
  assign ex_MemRead  = ctrl_q.mem_read;
  assign ex_MemWrite = ctrl_q.mem_write;
  assign ex_MemtoReg = ctrl_q.mem_to_reg;
  assign ex_ALUSrc1  = ctrl_q.alu_src1;
  assign ex_ALUSrc2  = ctrl_q.alu_src2;
  assign ex_ExtOp    = ctrl_q.ext_op;
  assign ex_LuOp     = ctrl_q.lu_op;
  assign ex_ALUOp    = ctrl_q.alu_op;
  assign ex_WriteReg = ctrl_q.write_reg;

endmodule

// File: tb/tb_pipelined_control.sv
// Testbench for pipelined_control: directed scenarios plus randomized
// instruction streams checked against a behavioural pipeline model.
module tb_pipelined_control;

`ifdef MULT_SEQ_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic [5:0] OpCode, Funct;
  logic [4:0] Rs, Rt, Rd;
  logic       flush;
  logic       stall_if, mul_busy, ex_valid;
  logic [1:0] ex_PCSrc, ex_RegDst, ex_MemtoReg;
  logic [2:0] ex_Branch;
  logic       ex_RegWrite, ex_MemRead, ex_MemWrite, ex_ALUSrc1, ex_ALUSrc2, ex_ExtOp, ex_LuOp;
  logic [3:0] ex_ALUOp;
  logic [4:0] ex_WriteReg;
  logic [25:0] act;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipelined_control #(.REG_ADDR_W(5), .ALUOP_W(4), .MUL_LATENCY(4)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .OpCode(OpCode), .Funct(Funct),
    .Rs(Rs), .Rt(Rt), .Rd(Rd), .flush(flush), .stall_if(stall_if), .mul_busy(mul_busy),
    .ex_valid(ex_valid), .ex_PCSrc(ex_PCSrc), .ex_Branch(ex_Branch), .ex_RegWrite(ex_RegWrite),
    .ex_RegDst(ex_RegDst), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
    .ex_MemtoReg(ex_MemtoReg), .ex_ALUSrc1(ex_ALUSrc1), .ex_ALUSrc2(ex_ALUSrc2),
    .ex_ExtOp(ex_ExtOp), .ex_LuOp(ex_LuOp), .ex_ALUOp(ex_ALUOp), .ex_WriteReg(ex_WriteReg)
  );

  assign act = {ex_valid, ex_PCSrc, ex_Branch, ex_RegWrite, ex_RegDst, ex_MemRead, ex_MemWrite,
                ex_MemtoReg, ex_ALUSrc1, ex_ALUSrc2, ex_ExtOp, ex_LuOp, ex_ALUOp, ex_WriteReg};

  // Reference decode written from the instruction-set rules; returns the full ID/EX bundle
  function automatic logic [25:0] ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                             input logic [4:0] rt, input logic [4:0] rd);
    logic [1:0] pcsrc, regdst, m2r;
    logic [2:0] br, cls;
    logic       rw, a1, a2;
    logic [4:0] wr;
    logic       jal_like, is_mul;
    jal_like = (op == 6'h03) || (op == 6'h00 && fn == 6'h09);
    is_mul   = (op == 6'h1c && fn == 6'h02);
    pcsrc = (op == 6'h02 || op == 6'h03) ? 2'd1 :
            (op == 6'h00 && (fn == 6'h08 || fn == 6'h09)) ? 2'd2 : 2'd0;
    br = (op == 6'h04) ? 3'd1 : (op == 6'h05) ? 3'd2 : (op == 6'h06) ? 3'd3 :
         (op == 6'h07) ? 3'd4 : (op == 6'h01) ? 3'd5 : 3'd0;
    rw = !(op == 6'h2b || br != 3'd0 || op == 6'h02 || (op == 6'h00 && fn == 6'h08));
    a2 = (op == 6'h23 || op == 6'h2b || op == 6'h0f || op == 6'h08 || op == 6'h09 ||
          op == 6'h0c || op == 6'h0a || op == 6'h0b);
    regdst = jal_like ? 2'd2 : (a2 && op != 6'h2b) ? 2'd0 : 2'd1;
    m2r = (op == 6'h23) ? 2'd1 : jal_like ? 2'd2 : 2'd0;
    a1 = (op == 6'h00) && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03);
    cls = (op == 6'h00) ? 3'b010 : (op == 6'h04 || op == 6'h05) ? 3'b001 :
          (op == 6'h0c) ? 3'b100 :
          (op == 6'h0a || op == 6'h0b || op == 6'h06 || op == 6'h07 || op == 6'h01) ? 3'b101 :
          is_mul ? 3'b110 : 3'b000;
    wr = (regdst == 2'd2) ? 5'd31 : (regdst == 2'd0) ? rt : rd;
    return {1'b1, pcsrc, br, rw, regdst, (op == 6'h23), (op == 6'h2b), m2r, a1, a2,
            (op != 6'h0c), (op == 6'h0f), op[0], cls, wr};
  endfunction

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic iv,
                       input logic fl);
    OpCode = op; Funct = fn; Rs = rs; Rt = rt; Rd = rd; instr_valid = iv; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_pipe();
    drive(6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    repeat (LAT + 1) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(6'h23, 6'h00, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    #2;
    n_tests++; if (act !== 26'd0) begin n_fail++; $display("FAIL reset_bundle got=%h exp=0", act); end
    n_tests++; if (stall_if !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall_if); end
    n_tests++; if (mul_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", mul_busy); end
    tick();
    n_tests++; if (act !== 26'd0) begin n_fail++; $display("FAIL reset_held got=%h exp=0", act); end
    reset = 1'b1;
    drive(6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL empty_slot got=%b exp=0", ex_valid); end
  endtask

  task automatic test_async_reset_mid_op();
    drive(6'h1c, 6'h02, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    tick();
    drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0);
    tick();
    n_tests++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid got=%b exp=1", ex_valid); end
    #1 reset = 1'b0;
    #1;
    n_tests++; if (act !== 26'd0) begin n_fail++; $display("FAIL async_reset_bundle got=%h exp=0", act); end
    n_tests++; if (stall_if !== 1'b0 || mul_busy !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_ctl got=%b%b exp=00", stall_if, mul_busy); end
    drive(6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    drive(6'h23, 6'h00, 5'd2, 5'd8, 5'd0, 1'b1, 1'b0);     // lw $8,0($2)
    tick();
    drive(6'h00, 6'h20, 5'd8, 5'd3, 5'd9, 1'b1, 1'b0);     // add $9,$8,$3
    #1;
    n_tests++; if (stall_if !== 1'b1) begin n_fail++; $display("FAIL lu_rs_stall got=%b exp=1", stall_if); end
    tick();
    n_tests++; if (ex_valid !== 1'b0 || stall_if !== 1'b0) begin
      n_fail++; $display("FAIL lu_bubble got=valid%b stall%b exp=00", ex_valid, stall_if); end
    tick();
    n_tests++; if ({ex_valid, ex_ALUOp, ex_RegDst, ex_WriteReg} !== {1'b1, 4'b0010, 2'b01, 5'd9}) begin
      n_fail++; $display("FAIL lu_add got=%b_%b_%b_%0d exp=1_0010_01_9",
                         ex_valid, ex_ALUOp, ex_RegDst, ex_WriteReg); end
    idle_pipe();
  endtask

  task automatic test_hazard_variants();
    drive(6'h23, 6'h00, 5'd2, 5'd8, 5'd0, 1'b1, 1'b0);     // lw $8
    tick();
    drive(6'h2b, 6'h00, 5'd4, 5'd8, 5'd0, 1'b1, 1'b0);     // sw $8,0($4)
    #1;
    n_tests++; if (stall_if !== 1'b1) begin n_fail++; $display("FAIL sw_rt_stall got=%b exp=1", stall_if); end
    tick();
    n_tests++; if (stall_if !== 1'b0) begin n_fail++; $display("FAIL sw_rt_release got=%b exp=0", stall_if); end
    tick();
    drive(6'h23, 6'h00, 5'd2, 5'd8, 5'd0, 1'b1, 1'b0);     // lw $8
    tick();
    drive(6'h08, 6'h00, 5'd8, 5'd5, 5'd0, 1'b1, 1'b0);     // addi $5,$8,1
    #1;
    n_tests++; if (stall_if !== 1'b1) begin n_fail++; $display("FAIL addi_rs_stall got=%b exp=1", stall_if); end
    tick();
    tick();
    drive(6'h23, 6'h00, 5'd2, 5'd8, 5'd0, 1'b1, 1'b0);     // lw $8
    tick();
    drive(6'h08, 6'h00, 5'd2, 5'd8, 5'd0, 1'b1, 1'b0);     // addi $8,$2,1: Rt only written
    #1;
    n_tests++; if (stall_if !== 1'b0) begin n_fail++; $display("FAIL addi_rt_nostall got=%b exp=0", stall_if); end
    tick();
    drive(6'h23, 6'h00, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0);     // lw $0
    tick();
    drive(6'h00, 6'h20, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);     // add $1,$0,$0
    #1;
    n_tests++; if (stall_if !== 1'b0) begin n_fail++; $display("FAIL r0_nostall got=%b exp=0", stall_if); end
    tick();
    n_tests++; if ({ex_valid, ex_WriteReg} !== {1'b1, 5'd1}) begin
      n_fail++; $display("FAIL r0_issue got=%b_%0d exp=1_1", ex_valid, ex_WriteReg); end
    idle_pipe();
  endtask

  task automatic test_jal_flush();
    drive(6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    tick();
    n_tests++; if ({ex_PCSrc, ex_RegDst, ex_MemtoReg, ex_WriteReg, ex_RegWrite} !==
                   {2'b01, 2'b10, 2'b10, 5'd31, 1'b1}) begin
      n_fail++; $display("FAIL jal_ctl got=%b_%b_%b_%0d_%b exp=01_10_10_31_1",
                         ex_PCSrc, ex_RegDst, ex_MemtoReg, ex_WriteReg, ex_RegWrite); end
    drive(6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    #1;
    n_tests++; if (stall_if !== 1'b0) begin n_fail++; $display("FAIL jal_flush_stall got=%b exp=0", stall_if); end
    tick();
    n_tests++; if (act !== 26'd0) begin n_fail++; $display("FAIL jal_flush_bubble got=%h exp=0", act); end
    drive(6'h23, 6'h00, 5'd2, 5'd8, 5'd0, 1'b1, 1'b0);
    tick();
    drive(6'h00, 6'h20, 5'd8, 5'd3, 5'd9, 1'b1, 1'b1);     // hazard, but flushed
    #1;
    n_tests++; if (stall_if !== 1'b0) begin n_fail++; $display("FAIL flush_over_hazard got=%b exp=0", stall_if); end
    tick();
    n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_hazard_bubble got=%b exp=0", ex_valid); end
    idle_pipe();
  endtask

`ifdef MULT_SEQ_EN
  task automatic test_mul_seq();
    drive(6'h1c, 6'h02, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    #1;
    n_tests++; if ({mul_busy, stall_if} !== 2'b00) begin
      n_fail++; $display("FAIL mul_c1 got=%b%b exp=00", mul_busy, stall_if); end
    tick();
    drive(6'h1c, 6'h02, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0);     // back-to-back mul
    for (int c = 2; c <= 4; c++) begin
      n_tests++; if ({mul_busy, stall_if, ex_valid, ex_ALUOp, ex_WriteReg} !== {3'b111, 4'b0110, 5'd3}) begin
        n_fail++; $display("FAIL mul_busy_c%0d got=%b%b%b_%b_%0d exp=111_0110_3",
                           c, mul_busy, stall_if, ex_valid, ex_ALUOp, ex_WriteReg); end
      tick();
    end
    n_tests++; if ({mul_busy, stall_if, ex_WriteReg} !== {2'b00, 5'd3}) begin
      n_fail++; $display("FAIL mul_c5 got=%b%b_%0d exp=00_3", mul_busy, stall_if, ex_WriteReg); end
    tick();
    drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0);
    n_tests++; if ({mul_busy, ex_WriteReg} !== {1'b1, 5'd7}) begin
      n_fail++; $display("FAIL mul_b2b got=%b_%0d exp=1_7", mul_busy, ex_WriteReg); end
    repeat (4) tick();
    n_tests++; if ({ex_valid, ex_ALUOp, ex_WriteReg} !== {1'b1, 4'b0010, 5'd4}) begin
      n_fail++; $display("FAIL mul_next got=%b_%b_%0d exp=1_0010_4", ex_valid, ex_ALUOp, ex_WriteReg); end
    idle_pipe();
  endtask

  task automatic test_mul_flush();
    drive(6'h1c, 6'h02, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    tick();
    drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
    tick();
    flush = 1'b1;
    #1;
    n_tests++; if (stall_if !== 1'b1) begin n_fail++; $display("FAIL mulflush_stall got=%b exp=1", stall_if); end
    tick();
    flush = 1'b0;
    tick();
    n_tests++; if ({mul_busy, stall_if} !== 2'b00) begin
      n_fail++; $display("FAIL mulflush_idle got=%b%b exp=00", mul_busy, stall_if); end
    tick();
    n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL mulflush_kill got=%b exp=0", ex_valid); end
    drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd6, 1'b1, 1'b0);
    tick();
    n_tests++; if ({ex_valid, ex_WriteReg} !== {1'b1, 5'd6}) begin
      n_fail++; $display("FAIL mulflush_next got=%b_%0d exp=1_6", ex_valid, ex_WriteReg); end
    idle_pipe();
  endtask
`else
  task automatic test_mul_single();
    drive(6'h1c, 6'h02, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    tick();
    drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0);
    #1;
    n_tests++; if ({mul_busy, stall_if, ex_ALUOp, ex_WriteReg} !== {2'b00, 4'b0110, 5'd3}) begin
      n_fail++; $display("FAIL mul_single got=%b%b_%b_%0d exp=00_0110_3",
                         mul_busy, stall_if, ex_ALUOp, ex_WriteReg); end
    tick();
    n_tests++; if ({ex_valid, ex_WriteReg} !== {1'b1, 5'd4}) begin
      n_fail++; $display("FAIL mul_single_next got=%b_%0d exp=1_4", ex_valid, ex_WriteReg); end
    idle_pipe();
  endtask
`endif

  task automatic pick(output logic [5:0] op, output logic [5:0] fn, output logic [4:0] rs,
                      output logic [4:0] rt, output logic [4:0] rd);
    case ($urandom_range(0, 17))
      0: op = 6'h00;  1: op = 6'h02;  2: op = 6'h03;  3: op = 6'h04;
      4: op = 6'h05;  5: op = 6'h06;  6: op = 6'h07;  7: op = 6'h01;
      8: op = 6'h23;  9: op = 6'h23;  10: op = 6'h2b; 11: op = 6'h0f;
      12: op = 6'h08; 13: op = 6'h09; 14: op = 6'h0c; 15: op = 6'h0a;
      16: op = 6'h1c; default: op = 6'($urandom_range(0, 63));
    endcase
    case ($urandom_range(0, 7))
      0: fn = 6'h00; 1: fn = 6'h02; 2: fn = 6'h03; 3: fn = 6'h08;
      4: fn = 6'h09; 5: fn = 6'h20; 6: fn = 6'h2a; default: fn = 6'($urandom_range(0, 63));
    endcase
    rs = 5'($urandom_range(0, 3));
    rt = 5'($urandom_range(0, 3));
    rd = 5'($urandom_range(0, 3));
  endtask

  task automatic test_random();
    logic [25:0] m_ex = '0;
    int          m_busy = 0;
    logic        m_kill = 1'b0;
    logic        haz, exp_stall, rd_rt;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    drive(6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    reset = 1'b0;
    #2 reset = 1'b1;
    pick(op, fn, rs, rt, rd);
    drive(op, fn, rs, rt, rd, 1'b1, 1'b0);
    for (int c = 0; c < 600; c++) begin
      rd_rt = (OpCode == 6'h00 || OpCode == 6'h04 || OpCode == 6'h05 || OpCode == 6'h2b);
      haz = m_ex[25] && m_ex[16] && (m_ex[4:0] != 5'd0) && instr_valid &&
            ((m_ex[4:0] == Rs) || ((m_ex[4:0] == Rt) && rd_rt));
      exp_stall = (haz && !flush && !m_kill) || (m_busy > 0);
      #1;
      n_tests++; if ({stall_if, mul_busy} !== {exp_stall, (m_busy > 0)}) begin
        n_fail++; $display("FAIL rand_ctl cyc=%0d got=%b%b exp=%b%b", c, stall_if, mul_busy,
                           exp_stall, (m_busy > 0)); end
      if (m_busy > 0) begin
        m_busy--;
        if (flush) m_kill = 1'b1;
      end else if (flush || m_kill) begin
        m_ex = '0; m_kill = 1'b0;
      end else if (haz || !instr_valid) begin
        m_ex = '0;
      end else begin
        m_ex = ref_decode(OpCode, Funct, Rt, Rd);
        if (OpCode == 6'h1c && Funct == 6'h02) m_busy = LAT - 1;
      end
      tick();
      n_tests++; if (act !== m_ex) begin
        n_fail++; $display("FAIL rand_ex cyc=%0d got=%h exp=%h", c, act, m_ex); end
      if (!exp_stall) pick(op, fn, rs, rt, rd);
      else begin op = OpCode; fn = Funct; rs = Rs; rt = Rt; rd = Rd; end
      drive(op, fn, rs, rt, rd, ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0));
    end
    idle_pipe();
  endtask

  initial begin
    test_reset();
    test_async_reset_mid_op();
    test_load_use();
    test_hazard_variants();
    test_jal_flush();
`ifdef MULT_SEQ_EN
    test_mul_seq();
    test_mul_flush();
`else
    test_mul_single();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
